// File: rtl/data_bus_bridge_if.sv
// External data bus seen by the bridge: request/acknowledge handshake with
// registered address, lane select and write data.
interface data_bus_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            sel;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/data_bus_bridge.sv
// Turns single-cycle MEM-stage accesses into req/ack bus transactions,
// stalling the CPU until completion or until the timeout forces it.
module data_bus_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [3:0]            cpu_byte_slct_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  input  logic                  cpu_we_i,
  input  logic                  cpu_re_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  stall_o,
  output logic                  timeout_err_o,
  data_bus_bridge_if.master     bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  terr_q, terr_d;
  logic                  act;

  assign act           = cpu_we_i | cpu_re_i;
  // The single DONE cycle is what lets the CPU pipeline advance.
  assign stall_o       = act & (state_q != S_DONE);

  assign cpu_rdata_o   = rdata_q;
  assign timeout_err_o = terr_q;
  assign bus.req       = req_q;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.sel       = sel_q;
  assign bus.wdata     = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    terr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (act) begin
          // A simultaneous load+store is issued as a store.
          addr_d  = cpu_addr_i;
          sel_d   = cpu_byte_slct_i;
          wdata_d = cpu_wdata_i;
          we_d    = cpu_we_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          req_d = 1'b0;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.ack) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = bus.rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = '0;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench: a per-cycle expected timeline is built from transaction
// descriptions and compared against the bridge every cycle.
module tb_data_bus_bridge;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam int NCYC = 92;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cpu_addr;
  logic [3:0]    cpu_sel;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic          cpu_re;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          terr;

  always #5 clk = ~clk;

  data_bus_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  data_bus_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_addr_i      (cpu_addr),
    .cpu_byte_slct_i (cpu_sel),
    .cpu_wdata_i     (cpu_wdata),
    .cpu_we_i        (cpu_we),
    .cpu_re_i        (cpu_re),
    .cpu_rdata_o     (cpu_rdata),
    .stall_o         (stall),
    .timeout_err_o   (terr),
    .bus             (bus_if)
  );

  // Stimulus plan
  bit            we_a[NCYC], re_a[NCYC], issue_a[NCYC], ack_a[NCYC];
  logic [AW-1:0] addr_a[NCYC];
  logic [3:0]    sel_a[NCYC];
  logic [DW-1:0] wdata_a[NCYC], ackd_a[NCYC];
  // Expected timeline
  bit            e_req[NCYC], e_done[NCYC], e_terr[NCYC], e_we[NCYC];
  logic [AW-1:0] e_addr[NCYC];
  logic [3:0]    e_sel[NCYC];
  logic [DW-1:0] e_wdata[NCYC], e_rd[NCYC];

  int cyc      = 0;
  bit checking = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  // One transaction issued in cycle s; bus acks d cycles after bus_req rises
  // (d >= TO means never). The CPU withdraws its request from cycle flush_at.
  task automatic plan(input int s, input bit we, input bit re, input logic [AW-1:0] a,
                      input logic [3:0] sl, input logic [DW-1:0] wd, input int d,
                      input logic [DW-1:0] rd, input int flush_at);
    bit to;
    int n;
    to = (d >= TO);
    n  = to ? TO : d + 1;
    issue_a[s] = 1'b1;
    addr_a[s]  = a;
    sel_a[s]   = sl;
    wdata_a[s] = wd;
    for (int c = s; c <= s + n + 1; c++) begin
      if (c < flush_at) begin
        we_a[c] = we;
        re_a[c] = re;
      end
    end
    for (int c = s + 1; c <= s + n; c++) begin
      e_req[c]   = 1'b1;
      e_we[c]    = we;
      e_addr[c]  = a;
      e_sel[c]   = sl;
      e_wdata[c] = wd;
    end
    if (!to) begin
      ack_a[s + 1 + d]  = 1'b1;
      ackd_a[s + 1 + d] = rd;
    end
    e_done[s + n + 1] = 1'b1;
    e_terr[s + n + 1] = to;
    if (re && !we) begin
      for (int c = s + n + 1; c < NCYC; c++) e_rd[c] = to ? '0 : rd;
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("stall", {63'd0, stall}, {63'd0, (we_a[cyc] | re_a[cyc]) & !e_done[cyc]});
      check("bus_req", {63'd0, bus_if.req}, {63'd0, e_req[cyc]});
      check("timeout_err", {63'd0, terr}, {63'd0, e_terr[cyc]});
      check("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, e_rd[cyc]});
      if (e_req[cyc]) begin
        check("bus_we", {63'd0, bus_if.we}, {63'd0, e_we[cyc]});
        check("bus_addr", {32'd0, bus_if.addr}, {32'd0, e_addr[cyc]});
        check("bus_sel", {60'd0, bus_if.sel}, {60'd0, e_sel[cyc]});
        check("bus_wdata", {32'd0, bus_if.wdata}, {32'd0, e_wdata[cyc]});
      end
      case (cyc)
        5:  check("lit_rd_stall_c0", {63'd0, stall}, 64'd1);
        6:  check("lit_rd_req", {63'd0, bus_if.req}, 64'd1);
        7: begin
          check("lit_rd_release", {63'd0, stall}, 64'd0);
          check("lit_rd_data", {32'd0, cpu_rdata}, 64'hDEADBEEF);
        end
        8:  check("lit_rd_req_off", {63'd0, bus_if.req}, 64'd0);
        14: begin
          check("lit_wr_sel", {60'd0, bus_if.sel}, 64'h3);
          check("lit_wr_wdata", {32'd0, bus_if.wdata}, 64'h1234);
        end
        15: begin
          check("lit_wr_release", {63'd0, stall}, 64'd0);
          check("lit_wr_rdata_hold", {32'd0, cpu_rdata}, 64'hDEADBEEF);
        end
        36: check("lit_to_req_last", {63'd0, bus_if.req}, 64'd1);
        37: begin
          check("lit_to_err", {63'd0, terr}, 64'd1);
          check("lit_to_rdata", {32'd0, cpu_rdata}, 64'd0);
          check("lit_to_release", {63'd0, stall}, 64'd0);
        end
        41: check("lit_wr_rd_we", {63'd0, bus_if.we}, 64'd1);
        48: check("lit_b2b_rel1", {63'd0, stall}, 64'd0);
        49: check("lit_b2b_stall2", {63'd0, stall}, 64'd1);
        50: check("lit_b2b_req2", {63'd0, bus_if.req}, 64'd1);
        55: check("lit_stray_ack", {32'd0, cpu_rdata}, 64'h22222222);
        64: check("lit_flush_data", {32'd0, cpu_rdata}, 64'hCAFEF00D);
        85: begin
          check("lit_lastack_err", {63'd0, terr}, 64'd0);
          check("lit_lastack_data", {32'd0, cpu_rdata}, 64'h600DF00D);
        end
        default: ;
      endcase
    end
  end

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      addr_a[c] = '0; sel_a[c] = '0; wdata_a[c] = '0; ackd_a[c] = '0;
      e_addr[c] = '0; e_sel[c] = '0; e_wdata[c] = '0; e_rd[c] = '0;
    end
    plan( 5, 1'b0, 1'b1, 32'h100, 4'hF, 32'h0,     0, 32'hDEADBEEF, NCYC);
    plan(10, 1'b1, 1'b0, 32'h20,  4'h3, 32'h1234,  3, 32'h0,        NCYC);
    plan(20, 1'b0, 1'b1, 32'h300, 4'hF, 32'h0,    99, 32'h0,        NCYC);
    plan(40, 1'b1, 1'b1, 32'h44,  4'hF, 32'hA5A5,  1, 32'h7777,     NCYC);
    plan(46, 1'b0, 1'b1, 32'h460, 4'h1, 32'h0,     0, 32'h11111111, NCYC);
    plan(49, 1'b0, 1'b1, 32'h490, 4'h2, 32'h0,     0, 32'h22222222, NCYC);
    plan(58, 1'b0, 1'b1, 32'h58,  4'hC, 32'h0,     4, 32'hCAFEF00D, 60);
    plan(68, 1'b0, 1'b1, 32'h68,  4'hF, 32'h0, TO - 1, 32'h600DF00D, NCYC);
    // Stray acks while DONE and while IDLE must be ignored.
    ack_a[51] = 1'b1; ackd_a[51] = 32'h0000BAD0;
    ack_a[54] = 1'b1; ackd_a[54] = 32'h00BADBAD;

    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_sel = '0; cpu_wdata = '0;
    bus_if.ack = 1'b0; bus_if.rdata = '0;
    @(posedge clk); #1;
    for (int c = 0; c < NCYC; c++) begin
      cyc    = c;
      rst    = (c < 3);
      cpu_we = we_a[c];
      cpu_re = re_a[c];
      if (issue_a[c]) begin
        cpu_addr = addr_a[c]; cpu_sel = sel_a[c]; cpu_wdata = wdata_a[c];
      end else begin
        cpu_addr = $urandom; cpu_sel = 4'($urandom); cpu_wdata = $urandom;
      end
      bus_if.ack   = ack_a[c];
      bus_if.rdata = ack_a[c] ? ackd_a[c] : $urandom;
      checking     = 1'b1;
      @(posedge clk); #1;
    end
    checking = 1'b0;

    // Asynchronous reset in the middle of a hung read.
    cyc = NCYC;
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h900; cpu_sel = 4'hF;
    bus_if.ack = 1'b0;
    @(posedge clk); #1;
    cyc = NCYC + 1;
    check("rst_pre_req", {63'd0, bus_if.req}, 64'd1);
    check("rst_pre_rdata", {32'd0, cpu_rdata}, 64'h600DF00D);
    #2 rst = 1'b1;
    #1;
    check("rst_req", {63'd0, bus_if.req}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd1);
    check("rst_rdata", {32'd0, cpu_rdata}, 64'd0);
    check("rst_terr", {63'd0, terr}, 64'd0);
    cpu_re = 1'b0;
    rst    = 1'b0;
    @(posedge clk); #1;
    check("rst_idle_req", {63'd0, bus_if.req}, 64'd0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
